// File: rtl/atm_account_server.sv
// Bank-side account responder: authenticates an account id + PIN, reports the
// verdict and balance, then accepts balance write-backs until the card is ejected.
module atm_account_server #(
    parameter int unsigned       balance_width = 20,
    parameter int unsigned       ID_W          = 2,
    parameter int unsigned       PIN_W         = 16,
    parameter logic [PIN_W-1:0]  PIN_BASE      = 16'h1234,
    parameter int unsigned       INIT_BALANCE  = 1000,
    parameter int unsigned       MAX_TRIES     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [ID_W-1:0]          req_id,
    input  logic [PIN_W-1:0]         req_pin,
    output logic                     req_ready,
    output logic                     resp_valid,
    output logic                     wrong_psw,
    output logic                     locked,
    output logic [balance_width-1:0] current_balance,
    output logic                     session_active,
    input  logic                     commit_valid,
    input  logic [balance_width-1:0] commit_balance,
    output logic                     commit_ready,
    input  logic                     session_end
);

    localparam int unsigned NumAccounts = 2 ** ID_W;

    typedef enum logic [1:0] {StIdle, StLookup, StRespond, StSession} state_e;

    state_e state_q, state_d;

    // Latched request
    logic [ID_W-1:0]          id_q;
    logic [PIN_W-1:0]         pin_q;

    // Registered lookup results for the latched account
    logic [PIN_W-1:0]         rd_pin_q;
    logic [balance_width-1:0] rd_bal_q;
    logic [1:0]               rd_fail_q;
    logic                     rd_lock_q;

    // Per-account storage; the PIN table is fixed at PIN_BASE + id
    logic [balance_width-1:0] bal_mem  [NumAccounts];
    logic [1:0]               fail_mem [NumAccounts];
    logic [NumAccounts-1:0]   lock_mem;

    // Registered verdict outputs
    logic                     resp_valid_q;
    logic                     wrong_psw_q;
    logic                     locked_q;
    logic [balance_width-1:0] cur_bal_q;

    logic                     pin_ok;
    logic [2:0]               fail_inc;
    logic                     lock_now;

    // Verdict helpers derived from the lookup registers
    always_comb begin
        pin_ok   = (pin_q == rd_pin_q);
        fail_inc = {1'b0, rd_fail_q} + 3'd1;
        lock_now = (fail_inc == 3'(MAX_TRIES));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req_valid) state_d = StLookup;
            StLookup:  state_d = StRespond;
            StRespond: state_d = (!rd_lock_q && pin_ok) ? StSession : StIdle;
            StSession: if (session_end) state_d = StIdle;
        endcase
    end

    // Request latch, lookup, verdict and account storage updates
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q         <= '0;
            pin_q        <= '0;
            rd_pin_q     <= '0;
            rd_bal_q     <= '0;
            rd_fail_q    <= '0;
            rd_lock_q    <= 1'b0;
            lock_mem     <= '0;
            resp_valid_q <= 1'b0;
            wrong_psw_q  <= 1'b0;
            locked_q     <= 1'b0;
            cur_bal_q    <= '0;
            for (int i = 0; i < NumAccounts; i++) begin
                bal_mem[i]  <= balance_width'(INIT_BALANCE);
                fail_mem[i] <= '0;
            end
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        id_q  <= req_id;
                        pin_q <= req_pin;
                    end
                end
                StLookup: begin
                    rd_pin_q  <= PIN_BASE + PIN_W'(id_q);
                    rd_bal_q  <= bal_mem[id_q];
                    rd_fail_q <= fail_mem[id_q];
                    rd_lock_q <= lock_mem[id_q];
                end
                StRespond: begin
                    resp_valid_q <= 1'b1;
                    if (rd_lock_q) begin
                        // Locked accounts never touch the failure counter
                        wrong_psw_q <= 1'b1;
                        locked_q    <= 1'b1;
                        cur_bal_q   <= '0;
                    end else if (!pin_ok) begin
                        wrong_psw_q <= 1'b1;
                        cur_bal_q   <= '0;
                        if (lock_now) begin
                            lock_mem[id_q] <= 1'b1;
                            fail_mem[id_q] <= '0;
                            locked_q       <= 1'b1;
                        end else begin
                            fail_mem[id_q] <= fail_inc[1:0];
                            locked_q       <= 1'b0;
                        end
                    end else begin
                        wrong_psw_q    <= 1'b0;
                        locked_q       <= 1'b0;
                        cur_bal_q      <= rd_bal_q;
                        fail_mem[id_q] <= '0;
                    end
                end
                StSession: begin
                    if (commit_valid) begin
                        bal_mem[id_q] <= commit_balance;
                        cur_bal_q     <= commit_balance;
                    end
                    // Later assignment wins: commit is stored, displayed balance clears
                    if (session_end) cur_bal_q <= '0;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == StIdle);
    assign session_active  = (state_q == StSession);
    assign commit_ready    = session_active;
    assign resp_valid      = resp_valid_q;
    assign wrong_psw       = wrong_psw_q;
    assign locked          = locked_q;
    assign current_balance = cur_bal_q;

endmodule

// File: tb/tb_atm_account_server.sv
// Randomized self-checking bench for atm_account_server against an account-level model.
module tb_atm_account_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_id;
    logic [15:0] req_pin;
    logic        req_ready;
    logic        resp_valid;
    logic        wrong_psw;
    logic        locked;
    logic [19:0] current_balance;
    logic        session_active;
    logic        commit_valid;
    logic [19:0] commit_balance;
    logic        commit_ready;
    logic        session_end;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: account records plus the held verdict outputs
    int m_bal  [4];
    int m_fail [4];
    bit m_lock [4];
    bit m_in_sess;
    int m_sid;
    bit e_wrong, e_locked;
    int e_bal;

    atm_account_server dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_id          (req_id),
        .req_pin         (req_pin),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .wrong_psw       (wrong_psw),
        .locked          (locked),
        .current_balance (current_balance),
        .session_active  (session_active),
        .commit_valid    (commit_valid),
        .commit_balance  (commit_balance),
        .commit_ready    (commit_ready),
        .session_end     (session_end)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bal[i]  = 1000;
            m_fail[i] = 0;
            m_lock[i] = 1'b0;
        end
        m_in_sess = 1'b0;
        e_wrong   = 1'b0;
        e_locked  = 1'b0;
        e_bal     = 0;
    endtask

    task automatic check_held(input string tag);
        check({tag, "_wrong"}, 32'(wrong_psw), 32'(e_wrong));
        check({tag, "_locked"}, 32'(locked), 32'(e_locked));
        check({tag, "_bal"}, 32'(current_balance), 32'(e_bal));
        check({tag, "_sess"}, 32'(session_active), 32'(m_in_sess));
        check({tag, "_cready"}, 32'(commit_ready), 32'(m_in_sess));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_resp", 32'(resp_valid), 32'(0));
        check_held("rst");
    endtask

    task automatic do_auth(input int id, input logic [15:0] pin);
        logic [15:0] good;
        good = 16'h1234 + 16'(id);
        if (m_lock[id]) begin
            e_wrong = 1'b1; e_locked = 1'b1; e_bal = 0;
        end else if (pin != good) begin
            m_fail[id]++;
            e_wrong = 1'b1; e_bal = 0;
            e_locked = (m_fail[id] == 3);
            if (e_locked) begin
                m_lock[id] = 1'b1;
                m_fail[id] = 0;
            end
        end else begin
            e_wrong = 1'b0; e_locked = 1'b0; e_bal = m_bal[id];
            m_fail[id] = 0;
            m_in_sess = 1'b1;
            m_sid = id;
        end
        @(negedge clk);
        req_valid = 1'b1; req_id = 2'(id); req_pin = pin;
        @(negedge clk);
        req_valid = 1'b0;
        check("auth_resp_lookup", 32'(resp_valid), 32'(0));
        check("auth_ready_busy", 32'(req_ready), 32'(0));
        @(negedge clk);
        check("auth_resp_early", 32'(resp_valid), 32'(0));
        @(negedge clk);
        check("auth_resp", 32'(resp_valid), 32'(1));
        check_held("auth");
        check("auth_ready", 32'(req_ready), 32'(!m_in_sess));
    endtask

    task automatic sess_op(input bit do_commit, input logic [19:0] val, input bit do_end);
        if (do_commit) begin
            m_bal[m_sid] = int'(val);
            e_bal = int'(val);
        end
        if (do_end) begin
            e_bal = 0;
            m_in_sess = 1'b0;
        end
        @(negedge clk);
        commit_valid = do_commit; commit_balance = val; session_end = do_end;
        @(negedge clk);
        commit_valid = 1'b0; session_end = 1'b0;
        check("sess_resp", 32'(resp_valid), 32'(0));
        check("sess_ready", 32'(req_ready), 32'(!m_in_sess));
        check_held("sess");
    endtask

    // Request while in session: must be ignored entirely
    task automatic spurious_req();
        @(negedge clk);
        req_valid = 1'b1; req_id = 2'($urandom_range(0, 3)); req_pin = 16'($urandom);
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("spur_resp", 32'(resp_valid), 32'(0));
        end
        check_held("spur");
    endtask

    // Commit or end while idle: must be ignored
    task automatic idle_commit(input logic [19:0] val);
        @(negedge clk);
        commit_valid = 1'b1; commit_balance = val; session_end = 1'b1;
        @(negedge clk);
        commit_valid = 1'b0; session_end = 1'b0;
        @(negedge clk);
        check("idle_commit_resp", 32'(resp_valid), 32'(0));
        check("idle_commit_ready", 32'(req_ready), 32'(1));
        check_held("idle_commit");
    endtask

    task automatic reset_in_lookup();
        @(negedge clk);
        req_valid = 1'b1; req_id = 2'd0; req_pin = 16'h1234;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rstlk_resp", 32'(resp_valid), 32'(0));
        check("rstlk_ready", 32'(req_ready), 32'(1));
        check_held("rstlk");
        @(negedge clk);
        check("rstlk_resp2", 32'(resp_valid), 32'(0));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_id = '0; req_pin = '0;
        commit_valid = 1'b0; commit_balance = '0; session_end = 1'b0;
        model_reset();

        // Basic auth, commit, re-auth
        do_reset();
        do_auth(1, 16'h1235);
        sess_op(1'b1, 20'd600, 1'b0);
        sess_op(1'b0, 20'd0, 1'b1);
        do_auth(1, 16'h1235);
        sess_op(1'b0, 20'd0, 1'b1);
        do_auth(2, 16'h1236);
        sess_op(1'b0, 20'd0, 1'b1);

        // Lockout after three wrong PINs, cleared only by reset
        for (int i = 0; i < 3; i++) do_auth(2, 16'h0000);
        do_auth(2, 16'h1236);
        do_reset();
        do_auth(2, 16'h1236);
        sess_op(1'b0, 20'd0, 1'b1);

        // A correct PIN clears the failure count
        do_auth(3, 16'hbeef);
        do_auth(3, 16'hbeef);
        do_auth(3, 16'h1237);
        sess_op(1'b0, 20'd0, 1'b1);
        do_auth(3, 16'hbeef);
        do_auth(3, 16'hbeef);

        // Commit and end in the same cycle
        do_auth(0, 16'h1234);
        sess_op(1'b1, 20'd750, 1'b1);
        do_auth(0, 16'h1234);

        // Ignored inputs, then reset during lookup
        spurious_req();
        sess_op(1'b0, 20'd0, 1'b1);
        idle_commit(20'd5);
        do_auth(0, 16'h1234);
        sess_op(1'b0, 20'd0, 1'b1);
        reset_in_lookup();

        // Randomized traffic
        for (int it = 0; it < 250; it++) begin
            if (m_in_sess) begin
                case ($urandom_range(0, 4))
                    0, 1: sess_op(1'b1, 20'($urandom), 1'b0);
                    2:    sess_op(1'b0, 20'd0, 1'b1);
                    3:    sess_op(1'b1, 20'($urandom), 1'b1);
                    default: spurious_req();
                endcase
            end else begin
                case ($urandom_range(0, 9))
                    0: do_reset();
                    1: idle_commit(20'($urandom));
                    2, 3, 4, 5: begin
                        int id;
                        id = int'($urandom_range(0, 3));
                        do_auth(id, 16'h1234 + 16'(id));
                    end
                    default: do_auth(int'($urandom_range(0, 3)), 16'($urandom));
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
